uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx.sv | 76 +++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver FSM state encoding and timing helper
package uart_rx_pkg;

    typedef enum logic [2:0] {
        s_IDLE,
        s_RX_START_BIT,
        s_RX_DATA_BITS,
        s_RX_STOP_BIT,
        s_CLEANUP
    } state_t;

    function automatic int half_bit(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line, idles high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic m;

    // shift the line through two flops; reset to the idle level so no false start
    always_ff @(posedge clk)
        if (rst) {m, q} <= 2'b11;
        else     {m, q} <= {d, m};

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and stop-bit framing check
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] H    = CW'(half_bit(CLKS_PER_BIT));
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift;
    logic          rx_s, tick, sample, stop_ok, stop_bad;

    uart_rx_sync u_sync (
        .clk (i_Clk),
        .rst (i_Rst),
        .d   (i_Rx_Serial),
        .q   (rx_s)
    );

    // state, counters, shift register and registered output pulses
    always_ff @(posedge i_Clk)
        if (i_Rst) begin
            state          <= s_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shift          <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            if (sample) shift[idx] <= rx_s;
            if (stop_ok) o_Rx_Byte <= shift;
            o_Rx_DV        <= stop_ok;
            o_Rx_Frame_Err <= stop_bad;
        end

    // next state; a start bit that is high at its midpoint is a glitch
    always_comb begin
        state_n = s_IDLE;
        case (state)
            s_IDLE:         state_n = rx_s ? s_IDLE : s_RX_START_BIT;
            s_RX_START_BIT: state_n = (cnt != H) ? s_RX_START_BIT : (rx_s ? s_IDLE : s_RX_DATA_BITS);
            s_RX_DATA_BITS: state_n = (tick && idx == 3'd7) ? s_RX_STOP_BIT : s_RX_DATA_BITS;
            s_RX_STOP_BIT:  state_n = tick ? s_CLEANUP : s_RX_STOP_BIT;
            s_CLEANUP:      state_n = rx_s ? s_IDLE : s_CLEANUP;
            default:        state_n = s_IDLE;
        endcase
    end

    // counter, bit index and sample strobes derived from the current state
    always_comb begin
        tick     = cnt == LAST;
        sample   = state == s_RX_DATA_BITS && tick;
        stop_ok  = state == s_RX_STOP_BIT && tick && rx_s;
        stop_bad = state == s_RX_STOP_BIT && tick && !rx_s;
        cnt_n    = ((state == s_RX_START_BIT && cnt != H) ||
                    ((state == s_RX_DATA_BITS || state == s_RX_STOP_BIT) && !tick)) ? cnt + 1'b1 : '0;
        idx_n    = sample ? idx + 3'd1 : (state == s_RX_DATA_BITS ? idx : 3'd0);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with a behavioural 8N1 transmitter
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB = 8;
    localparam int H   = (CPB - 1) / 2;
    localparam int LAT = 1 + 3 + H + 9 * CPB;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv, fe;
    logic [7:0] byte_out;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       dvq[$];
    int         feq[$];
    vec_t       vecs[5];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (byte_out),
        .o_Rx_Frame_Err (fe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        if (stop) begin
            e.b = b;
            e.t = cyc + LAT;
            dvq.push_back(e);
        end else feq.push_back(cyc + LAT);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    always @(negedge clk)
        if (!rst) begin
            if (dv || fe) check("dv_fe_exclusive", {31'd0, dv & fe}, 32'd0);
            if (dv) begin
                if (dvq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dv byte=%0h at cycle %0d", byte_out, cyc);
                end else begin
                    exp_t e;
                    e = dvq.pop_front();
                    check("rx_byte", {24'd0, byte_out}, {24'd0, e.b});
                    check("dv_time", cyc, e.t);
                    last_good = e.b;
                end
            end
            if (fe) begin
                if (feq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err at cycle %0d", cyc);
                end else begin
                    int t;
                    t = feq.pop_front();
                    check("fe_time", cyc, t);
                    check("byte_hold", {24'd0, byte_out}, {24'd0, last_good});
                end
            end
        end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1};
        vecs[1] = '{8'h00, 1'b1};
        vecs[2] = '{8'hFF, 1'b1};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h81, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dv", {31'd0, dv}, 32'd0);
        check("reset_fe", {31'd0, fe}, 32'd0);
        check("reset_byte", {24'd0, byte_out}, 32'd0);
        check("reset_state", {29'd0, dut.state}, {29'd0, s_IDLE});
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(4);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                rx = 1'b1;
                cycles(CPB);
            end
        end
        cycles(CPB);

        rx = 1'b0;
        cycles(2);
        rx = 1'b1;
        cycles(20);
        check("glitch_idle", {29'd0, dut.state}, {29'd0, s_IDLE});

        send_frame(8'h3C, 1'b0);
        cycles(40);
        check("break_cleanup", {29'd0, dut.state}, {29'd0, s_CLEANUP});
        rx = 1'b1;
        cycles(4);
        check("break_release", {29'd0, dut.state}, {29'd0, s_IDLE});
        cycles(CPB);

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx = 1'b1;
        cycles(3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_dv", {31'd0, dv}, 32'd0);
        check("midreset_fe", {31'd0, fe}, 32'd0);
        check("midreset_byte", {24'd0, byte_out}, 32'd0);
        check("midreset_state", {29'd0, dut.state}, {29'd0, s_IDLE});
        @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        cycles(2 * CPB);
        send_frame(8'h5A, 1'b1);
        cycles(CPB);

        for (int i = 0; i < 256; i++) send_frame(i[7:0], 1'b1);

        cycles(20);
        check("dv_queue_empty", dvq.size(), 32'd0);
        check("fe_queue_empty", feq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
